// File: rtl/bp_nonsynth_commit_replay.sv
// bp_nonsynth_commit_replay
// Replays a stream of pre-recorded commit records as a core's commit and
// register-writeback interface. It presents each accepted record as a one-cycle
// commit pulse. The register writeback it carries appears some cycles later,
// taken from a delay line. Writebacks always leave in commit order.
//
// Ports
//   clk_i, reset_i      clock (rising edge) and asynchronous active-low reset
//   freeze_i            holds off record acceptance only
//   rec_v_i/rec_ready_o record handshake; a record is taken when both are high
//   rec_*_i             record contents: pc, instr, trap/cause, writeback
//                       flags/addr/data, idle gap and writeback delay
//   commit_*_o          registered commit pulse, one cycle after acceptance
//   iwb_*_o, fwb_*_o    integer / floating-point writeback pulses
//   instr_cnt_o         saturating count of retired instructions
//   idle_o              nothing pending: ready state, empty delay line, no commit
module bp_nonsynth_commit_replay #(
  parameter int vaddr_width_p = 39,
  parameter int max_delay_p   = 15
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     freeze_i,
  input  logic                     rec_v_i,
  output logic                     rec_ready_o,
  input  logic [vaddr_width_p-1:0] rec_pc_i,
  input  logic [31:0]              rec_instr_i,
  input  logic                     rec_trap_i,
  input  logic [63:0]              rec_cause_i,
  input  logic                     rec_irf_w_i,
  input  logic                     rec_frf_w_i,
  input  logic [4:0]               rec_rd_addr_i,
  input  logic [63:0]              rec_data_i,
  input  logic [3:0]               rec_gap_i,
  input  logic [3:0]               rec_delay_i,
  output logic                     commit_v_o,
  output logic [vaddr_width_p-1:0] commit_pc_o,
  output logic [31:0]              commit_instr_o,
  output logic                     commit_instret_o,
  output logic                     commit_exception_o,
  output logic [63:0]              commit_cause_o,
  output logic                     iwb_v_o,
  output logic [4:0]               iwb_addr_o,
  output logic [63:0]              iwb_data_o,
  output logic                     fwb_v_o,
  output logic [4:0]               fwb_addr_o,
  output logic [63:0]              fwb_data_o,
  output logic [31:0]              instr_cnt_o,
  output logic                     idle_o
);

  typedef enum logic {e_ready, e_gap} state_e;

  state_e      r_state, w_stateNext;
  logic [3:0]  r_gapCnt, w_gapCntNext;

  // Delay line: slot 0 is the writeback being presented this cycle, slot k
  // will be presented k cycles from now.
  logic [max_delay_p:0] r_slotV, w_slotVNext;
  logic [max_delay_p:0] r_slotFp, w_slotFpNext;
  logic [4:0]           r_slotAddr [0:max_delay_p];
  logic [4:0]           w_slotAddrNext [0:max_delay_p];
  logic [63:0]          r_slotData [0:max_delay_p];
  logic [63:0]          w_slotDataNext [0:max_delay_p];

  logic                     r_commitV;
  logic [vaddr_width_p-1:0] r_commitPc;
  logic [31:0]              r_commitInstr;
  logic                     r_commitTrap;
  logic [63:0]              r_commitCause;
  logic [31:0]              r_instrCnt;

  int   w_delay;
  int   w_newest;
  logic w_wbRec;
  logic w_orderStall;
  logic w_accept;

  // A new writeback lands in slot d on the accepting edge. Any pending entry
  // sitting above slot d now would come out at or after it, so stall.
  always_comb begin
    w_delay = int'(rec_delay_i);
    if (w_delay > max_delay_p) w_delay = max_delay_p;
    w_wbRec  = ~rec_trap_i & (rec_irf_w_i | rec_frf_w_i);
    w_newest = -1;
    for (int j = 0; j <= max_delay_p; j++) begin
      if (r_slotV[j]) w_newest = j;
    end
    w_orderStall = w_wbRec & (w_newest > w_delay);
  end

  assign rec_ready_o = reset_i & (r_state == e_ready) & ~freeze_i & ~w_orderStall;
  assign w_accept    = rec_v_i & rec_ready_o;

  always_comb begin
    w_stateNext  = r_state;
    w_gapCntNext = r_gapCnt;
    case (r_state)
      e_ready: begin
        if (w_accept && (rec_gap_i != 4'd0)) begin
          w_stateNext  = e_gap;
          w_gapCntNext = rec_gap_i;
        end
      end
      e_gap: begin
        if (r_gapCnt <= 4'd1) begin
          w_stateNext  = e_ready;
          w_gapCntNext = 4'd0;
        end else begin
          w_gapCntNext = r_gapCnt - 4'd1;
        end
      end
      default: begin
        w_stateNext  = e_ready;
        w_gapCntNext = 4'd0;
      end
    endcase
  end

  always_comb begin
    for (int j = 0; j < max_delay_p; j++) begin
      w_slotVNext[j]    = r_slotV[j+1];
      w_slotFpNext[j]   = r_slotFp[j+1];
      w_slotAddrNext[j] = r_slotAddr[j+1];
      w_slotDataNext[j] = r_slotData[j+1];
    end
    w_slotVNext[max_delay_p]    = 1'b0;
    w_slotFpNext[max_delay_p]   = 1'b0;
    w_slotAddrNext[max_delay_p] = 5'd0;
    w_slotDataNext[max_delay_p] = 64'd0;
    if (w_accept && w_wbRec) begin
      for (int j = 0; j <= max_delay_p; j++) begin
        if (j == w_delay) begin
          w_slotVNext[j]    = 1'b1;
          // Integer file wins when both flags are set.
          w_slotFpNext[j]   = ~rec_irf_w_i;
          w_slotAddrNext[j] = rec_rd_addr_i;
          w_slotDataNext[j] = (rec_irf_w_i && (rec_rd_addr_i == 5'd0)) ? 64'd0 : rec_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state       <= e_ready;
      r_gapCnt      <= 4'd0;
      r_slotV       <= '0;
      r_slotFp      <= '0;
      r_slotAddr    <= '{default: '0};
      r_slotData    <= '{default: '0};
      r_commitV     <= 1'b0;
      r_commitPc    <= '0;
      r_commitInstr <= '0;
      r_commitTrap  <= 1'b0;
      r_commitCause <= '0;
      r_instrCnt    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_gapCnt   <= w_gapCntNext;
      r_slotV    <= w_slotVNext;
      r_slotFp   <= w_slotFpNext;
      r_slotAddr <= w_slotAddrNext;
      r_slotData <= w_slotDataNext;
      r_commitV  <= w_accept;
      if (w_accept) begin
        r_commitPc    <= rec_pc_i;
        r_commitInstr <= rec_instr_i;
        r_commitTrap  <= rec_trap_i;
        r_commitCause <= rec_trap_i ? rec_cause_i : 64'd0;
        if (!rec_trap_i && (r_instrCnt != '1)) r_instrCnt <= r_instrCnt + 32'd1;
      end
    end
  end

  assign commit_v_o         = r_commitV;
  assign commit_pc_o        = r_commitPc;
  assign commit_instr_o     = r_commitInstr;
  assign commit_instret_o   = r_commitV & ~r_commitTrap;
  assign commit_exception_o = r_commitV & r_commitTrap;
  assign commit_cause_o     = r_commitCause;

  assign iwb_v_o    = r_slotV[0] & ~r_slotFp[0];
  assign iwb_addr_o = iwb_v_o ? r_slotAddr[0] : 5'd0;
  assign iwb_data_o = iwb_v_o ? r_slotData[0] : 64'd0;
  assign fwb_v_o    = r_slotV[0] & r_slotFp[0];
  assign fwb_addr_o = fwb_v_o ? r_slotAddr[0] : 5'd0;
  assign fwb_data_o = fwb_v_o ? r_slotData[0] : 64'd0;

  assign instr_cnt_o = r_instrCnt;
  assign idle_o      = (r_state == e_ready) & ~(|r_slotV) & ~r_commitV;

endmodule

// File: doc/bp_nonsynth_commit_replay.md
BP_NONSYNTH_COMMIT_REPLAY -- requirements
Module: bp_nonsynth_commit_replay

Interface
REQ-001 The block SHALL have parameter vaddr_width_p, default 39, commit PC width.
REQ-002 The block SHALL have parameter max_delay_p, default 15, maximum writeback delay in cycles.
REQ-003 The block SHALL have port clk_i, input, 1, clock; all state on rising edge.
REQ-004 The block SHALL have port reset_i, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port freeze_i, input, 1, blocks record acceptance.
REQ-006 The block SHALL have ports rec_v_i (input, 1, record valid) and rec_ready_o (output, 1, record accepted when both high).
REQ-007 The block SHALL have record inputs: rec_pc_i vaddr_width_p; rec_instr_i 32; rec_trap_i 1; rec_cause_i 64; rec_irf_w_i 1; rec_frf_w_i 1; rec_rd_addr_i 5; rec_data_i 64; rec_gap_i 4 (idle cycles after commit); rec_delay_i 4 (writeback delay).
REQ-008 The block SHALL have commit outputs: commit_v_o 1; commit_pc_o vaddr_width_p; commit_instr_o 32; commit_instret_o 1; commit_exception_o 1; commit_cause_o 64.
REQ-009 The block SHALL have writeback outputs: iwb_v_o 1, iwb_addr_o 5, iwb_data_o 64; fwb_v_o 1, fwb_addr_o 5, fwb_data_o 64.
REQ-010 The block SHALL have outputs instr_cnt_o (32, retired-instruction count) and idle_o (1, nothing pending).

Function
REQ-011 FSM states SHALL be e_ready and e_gap; rec_ready_o = (state==e_ready) & ~freeze_i & ~order_stall.
REQ-012 Record accepted at edge t SHALL drive commit_v_o=1 with its pc/instr for exactly cycle t+1 (latency 1); commit_v_o=0 otherwise.
REQ-013 Non-trap record: commit_instret_o=1, commit_exception_o=0, commit_cause_o=0.
REQ-014 Trap record: commit_instret_o=0, commit_exception_o=1, commit_cause_o=rec_cause_i, no writeback regardless of irf/frf flags.
REQ-015 Non-trap record with irf_w (or both flags set; irf wins) SHALL pulse iwb_v_o for one cycle at t+1+d, d=min(rec_delay_i, max_delay_p); frf_w only: fwb_v_o likewise.
REQ-016 Integer writeback to rd_addr 0 SHALL be emitted with iwb_data_o forced to 0.
REQ-017 Pending writebacks SHALL be held in a max_delay_p+1 slot delay line, each slot carrying type, addr, data; slots advance one per cycle.
REQ-018 order_stall SHALL be high when a new writeback's due cycle would not be strictly later than the newest pending writeback's due cycle; records without writeback never order-stall.
REQ-019 Writebacks SHALL therefore leave in commit order, at most one per cycle, never colliding.
REQ-020 Accept with rec_gap_i=g>0 SHALL enter e_gap for exactly g cycles, then e_ready; g=0 stays in e_ready (back-to-back accepts allowed).
REQ-021 freeze_i SHALL only block acceptance; gap counting and writeback draining continue.
REQ-022 instr_cnt_o SHALL increment by 1 per commit with instret=1, saturating at 2^32-1.
REQ-023 idle_o SHALL be high when state==e_ready, delay line empty, commit_v_o=0.
REQ-024 All valid outputs SHALL be registered; no combinational path from rec_* to commit/writeback outputs.

Reset
REQ-025 While reset_i=0: state e_ready, delay line empty, gap counter 0, instr_cnt_o=0, all *_v_o=0, all data/addr outputs 0, rec_ready_o=0, idle_o=1.
REQ-026 Reset asserted mid-operation SHALL discard pending writebacks and gap count immediately; no pending writeback is emitted after release.
REQ-027 First record SHALL be acceptable on the first rising edge after reset_i rises.

Verification
REQ-028 Record pc=0x80000000, irf, rd=5, data=0x1234, delay=0, gap=0 -> commit_v_o at t+1, iwb_v_o addr 5 data 0x1234 same cycle, instr_cnt_o=1.
REQ-029 Records A (irf, delay=8) then B (frf, delay=2) -> rec_ready_o low until B's writeback due after A's; iwb for A precedes fwb for B.
REQ-030 Trap record cause=0x2 with irf=1 -> commit_exception_o=1, commit_cause_o=0x2, instret=0, no iwb pulse, instr_cnt_o unchanged.
REQ-031 gap=3 then next record valid -> next accept exactly 4 cycles later; freeze_i high 10 cycles with pending delay=6 writeback -> writeback emitted on time, no accept.
REQ-032 Reset pulsed while delay=12 writeback pending -> no iwb/fwb pulse after release, idle_o=1, instr_cnt_o=0.
